// File: rtl/frame_stream_arbiter_pkg.sv
// rtl/frame_stream_arbiter_pkg.sv - shared video packet types and arbiter state encoding
package frame_stream_arbiter_pkg;

  // Packet type is carried in the low nibble of the sop beat.
  localparam logic [3:0] HDR_CTRL = 4'd15;
  localparam logic [3:0] HDR_DATA = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CTRL  = 2'd1,
    ST_DATA  = 2'd2,
    ST_OTHER = 2'd3
  } arb_state_e;

  // Beat qualifiers that travel alongside the data word.
  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [1:0] empty;
  } beat_ctl_t;

  // Map a packet header nibble to the state that owns the rest of the packet.
  function automatic arb_state_e classify_hdr(input logic [3:0] hdr);
    if (hdr == HDR_CTRL) begin
      return ST_CTRL;
    end else if (hdr == HDR_DATA) begin
      return ST_DATA;
    end
    return ST_OTHER;
  endfunction

endpackage

// File: rtl/frame_stream_arbiter_vid_out_reg.sv
// rtl/frame_stream_arbiter_vid_out_reg.sv - single output register stage with ready/valid handshake
module vid_out_reg
  import frame_stream_arbiter_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  beat_ctl_t         in_ctl_i,
  output logic              can_accept_o,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output beat_ctl_t         out_ctl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  beat_ctl_t         ctl_q, ctl_d;

  // A new beat may enter when the register is empty or is draining this cycle.
  assign can_accept_o = !valid_q || out_ready_i;

  // Load a new beat, otherwise drop valid once the sink has taken the held one.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctl_d   = ctl_q;
    if (in_valid_i) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      ctl_d   = in_ctl_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register; data is held unchanged while the sink stalls.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctl_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctl_q   <= ctl_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_ctl_o   = ctl_q;

endmodule

// File: rtl/frame_stream_arbiter.sv
// rtl/frame_stream_arbiter.sv - two-source packet arbiter merging video streams onto one output
module frame_stream_arbiter
  import frame_stream_arbiter_pkg::*;
#(
  parameter int DATA_W        = 24,
  parameter int PRIORITY_MODE = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              s0_valid,
  input  logic              s0_sop,
  input  logic              s0_eop,
  input  logic [DATA_W-1:0] s0_data,
  input  logic [1:0]        s0_empty,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic              s1_sop,
  input  logic              s1_eop,
  input  logic [DATA_W-1:0] s1_data,
  input  logic [1:0]        s1_empty,
  output logic              s1_ready,
  output logic              dout_valid,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [DATA_W-1:0] dout_data,
  output logic [1:0]        dout_empty,
  input  logic              dout_ready,
  output logic              grant,
  output logic [7:0]        err_cnt
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              ctrl_done_q, ctrl_done_d;
  logic [7:0]        err_q, err_d;

  logic [1:0]        src_valid, src_sop, req, orphan, ready;
  logic              win, sel, fwd, can_accept;
  logic              sel_valid, sel_sop, sel_eop;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_empty;
  arb_state_e        hdr_class;
  logic [8:0]        err_sum;
  beat_ctl_t         sel_ctl, out_ctl;

  assign src_valid = {s1_valid, s0_valid};
  assign src_sop   = {s1_sop, s0_sop};
  assign req       = src_valid & src_sop;
  assign orphan    = src_valid & ~src_sop;

  // Winner among sources offering a start-of-packet while the output is free.
  always_comb begin
    win = req[1];
    if (&req) begin
      win = (PRIORITY_MODE != 0) ? 1'b0 : ~last_q;
    end
  end

  assign sel       = (state_q == ST_IDLE) ? win : grant_q;
  assign sel_valid = sel ? s1_valid : s0_valid;
  assign sel_sop   = sel ? s1_sop   : s0_sop;
  assign sel_eop   = sel ? s1_eop   : s0_eop;
  assign sel_data  = sel ? s1_data  : s0_data;
  assign sel_empty = sel ? s1_empty : s0_empty;
  assign sel_ctl   = {sel_sop, sel_eop, sel_empty};
  assign hdr_class = classify_hdr(sel_data[3:0]);
  assign err_sum   = {1'b0, err_q} + {8'd0, orphan[0]} + {8'd0, orphan[1]};

  // Handshake, packet tracking and ownership; orphans are swallowed only while idle.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    ctrl_done_d = ctrl_done_q;
    err_d       = err_q;
    ready       = 2'b00;
    fwd         = 1'b0;
    if (!reset_n) begin
      ready = 2'b00;
    end else if (state_q == ST_IDLE) begin
      ready = orphan;
      err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
      if ((|req) && can_accept) begin
        ready[win] = 1'b1;
        fwd        = 1'b1;
        grant_d    = win;
        if (sel_eop && (hdr_class != ST_CTRL)) begin
          last_d = win;
        end else begin
          state_d     = hdr_class;
          ctrl_done_d = sel_eop;
        end
      end
    end else begin
      ready[grant_q] = can_accept;
      fwd            = can_accept & sel_valid;
      if (fwd) begin
        if (state_q == ST_CTRL) begin
          if (!ctrl_done_q) begin
            ctrl_done_d = sel_eop;
          end else if (sel_sop) begin
            ctrl_done_d = 1'b0;
            if (sel_eop) begin
              state_d = ST_IDLE;
              last_d  = grant_q;
            end else begin
              state_d = (sel_data[3:0] == HDR_DATA) ? ST_DATA : ST_OTHER;
            end
          end
        end else if (sel_eop) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
    end
  end

  // Arbiter state registers; last-served starts at 1 so source 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      ctrl_done_q <= 1'b0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      ctrl_done_q <= ctrl_done_d;
      err_q       <= err_d;
    end
  end

  vid_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid_i   (fwd),
    .in_data_i    (sel_data),
    .in_ctl_i     (sel_ctl),
    .can_accept_o (can_accept),
    .out_ready_i  (dout_ready),
    .out_valid_o  (dout_valid),
    .out_data_o   (dout_data),
    .out_ctl_o    (out_ctl)
  );

  assign dout_sop   = out_ctl.sop;
  assign dout_eop   = out_ctl.eop;
  assign dout_empty = out_ctl.empty;
  assign s0_ready   = ready[0];
  assign s1_ready   = ready[1];
  assign grant      = grant_q;
  assign err_cnt    = err_q;

endmodule

// File: doc/frame_stream_arbiter.md
FRAME_STREAM_ARBITER -- requirements
Module: frame_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel/header beat width.
REQ-002 SHALL have parameter PRIORITY_MODE, default 0, 0 = round-robin, 1 = fixed priority to source 0.
REQ-003 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous active-low reset.
REQ-005 SHALL have ports s0_valid, s0_sop, s0_eop  in  1 each  source 0 Avalon-ST video beat qualifiers.
REQ-006 SHALL have ports s0_data  in  DATA_W, and s0_empty  in  2; source 0 beat data and empty.
REQ-007 SHALL have port s0_ready  out  1  source 0 accept.
REQ-008 SHALL have ports s1_valid, s1_sop, s1_eop, s1_data, s1_empty, s1_ready for source 1, with the same directions and widths as source 0.
REQ-009 SHALL have ports dout_valid, dout_sop, dout_eop  out  1 each; dout_data  out  DATA_W; dout_empty  out  2; merged output stream.
REQ-010 SHALL have port dout_ready  in  1  sink accept.
REQ-011 SHALL have port grant  out  1  index of source currently owning the output.
REQ-012 SHALL have port err_cnt  out  8  saturating count of discarded orphan beats.

Function
REQ-013 SHALL pass beats through one output register stage; latency is 1 cycle from accepted input beat to dout_valid.
REQ-014 SHALL accept a beat (sN_valid & sN_ready) only when the output register is empty or dout_ready=1 in the same cycle.
REQ-015 SHALL hold dout_* stable while dout_valid=1 and dout_ready=0.
REQ-016 SHALL implement FSM states IDLE, CTRL, DATA and OTHER.
REQ-017 SHALL, in IDLE, treat a source as requesting when valid=1 and sop=1.
REQ-018 SHALL, in IDLE with PRIORITY_MODE=0, grant the requester other than the last-served source when both request, and otherwise grant the sole requester.
REQ-019 SHALL, in IDLE with PRIORITY_MODE=1, grant source 0 whenever it requests.
REQ-020 SHALL accept the granted sop beat in the same cycle the grant is decided, classify it by data[3:0], and move to CTRL (header 15), DATA (header 0) or OTHER (any other header).
REQ-021 SHALL keep the grant in CTRL through the control packet eop, then stay on the same source awaiting its next sop.
REQ-022 SHALL, in CTRL after the control eop, move to DATA if the next sop header is 0 and to OTHER otherwise, without changing the grant.
REQ-023 SHALL, in DATA or OTHER, return to IDLE on the accepted eop beat and update the last-served source.
REQ-024 SHALL drive the non-granted source's ready to 0 outside IDLE.
REQ-025 SHALL, in IDLE, discard (ready=1, no output) any valid beat with sop=0 and increment err_cnt, saturating at 255.
REQ-026 SHALL, on a single-beat packet (sop=1 and eop=1) whose header is not 15, return directly to IDLE.
REQ-027 SHALL, when both sources present an orphan beat in the same cycle, increment err_cnt by 2, saturating.
REQ-028 SHALL forward empty unchanged.

Reset
REQ-029 SHALL, when reset_n=0 at a clock edge, set state=IDLE, dout_valid=0, dout_sop=0, dout_eop=0, dout_data=0, dout_empty=0, grant=0, last-served=1 (so source 0 wins the first tie), and err_cnt=0.
REQ-030 SHALL drive s0_ready=0 and s1_ready=0 while reset_n=0.
REQ-031 SHALL, when reset occurs mid-packet, drop the partial packet with no eop emitted.

Structure
REQ-032 SHALL place the packet-type constants (CTRL header 15, DATA header 0) and the FSM state encoding in the shared video package.
REQ-033 SHALL implement the output register/handshake as one sub-module, vid_out_reg; arbitration and FSM stay in the top.

Verification
REQ-034 SHALL cover: with only s0 sending ctrl(3 beats)+data(4 beats), the same 7 beats appear on dout 1 cycle later, and grant=0 throughout.
REQ-035 SHALL cover: with both sources asserting sop in the same cycle after reset in RR mode, s0 is served first, s1 second, and s0 third in the next tie.
REQ-036 SHALL cover: with s1 asserting sop while s0 is between its ctrl eop and its data sop, s1_ready=0 until s0's data eop.
REQ-037 SHALL cover: with dout_ready=0 for 5 cycles mid-packet, dout_* stays frozen, sN_ready=0, and no beat is lost or duplicated.
REQ-038 SHALL cover: 3 orphan beats in IDLE give err_cnt=3; 300 orphan beats give err_cnt=255.
REQ-039 SHALL cover: reset_n=0 on beat 2 of a data packet gives dout_valid=0 next cycle, and the next packet is arbitrated normally.
